acc_core_ctrl: RTL and testbench
================================

Name: acc_core_ctrl

Overview:
Multi-cycle control unit and accumulator datapath for the simple processor. It fetches 8-bit instructions from a single shared memory over a req/ack handshake, decodes them, and executes them against an internal accumulator. It owns PC, IR, ACC and the Z/C flags. The existing bitwise primitives, including and_gate, are leaf cells inside its ALU.

Parameters:
DATA_WIDTH, 8, memory word and accumulator width; must equal 4 + ADDR_WIDTH (SIMULATION initial check flags a violation)
ADDR_WIDTH, 4, memory address and PC width

Ports:
clk_i  input  1  clock, all logic on rising edge
rst_i  input  1  synchronous active-high reset
start_i  input  1  pulse; leaves IDLE/HALT and begins fetching at PC=0
mem_req_o  output  1  memory request valid
mem_we_o  output  1  1=write, 0=read; valid while mem_req_o=1
mem_addr_o  output  ADDR_WIDTH  request address
mem_wdata_o  output  DATA_WIDTH  write data (ACC)
mem_rdata_i  input  DATA_WIDTH  read data; valid in the cycle mem_ack_i=1
mem_ack_i  input  1  request completes in the cycle ack=1 while req=1
acc_o  output  DATA_WIDTH  accumulator
pc_o  output  ADDR_WIDTH  program counter
z_o  output  1  zero flag
c_o  output  1  carry/borrow flag
halted_o  output  1  high in HALT

Behaviour:
- Reset (sync, highest priority, valid in any state): state=IDLE, PC=0, ACC=0, IR=0, Z=0, C=0, mem_req_o=0, mem_we_o=0, halted_o=0. An in-flight request is dropped; mem_req_o is low in the cycle after rst_i is sampled.
- Instruction format: [7:4] opcode, [3:0] addr. Opcodes: 0 NOP, 1 LDA, 2 STA, 3 ADD, 4 SUB, 5 AND, 6 OR, 7 JMP, 8 JZ, F HLT. Undefined opcodes execute as NOP.
- States:
  - IDLE: start_i → FETCH, PC=0.
  - FETCH: req=1, we=0, addr=PC. On ack: IR<=rdata, PC<=PC+1 (wraps at 2^ADDR_WIDTH−1 to 0) → DECODE.
  - DECODE (1 cycle, no req):
    - LDA/ADD/SUB/AND/OR → MEM_RD.
    - STA → MEM_WR.
    - JMP: PC<=addr → FETCH.
    - JZ: if Z then PC<=addr → FETCH.
    - HLT → HALT.
    - NOP/undefined → FETCH.
  - MEM_RD: req=1, we=0, addr=IR.addr. On ack: operand<=rdata → EXEC.
  - EXEC (1 cycle): ACC<=result → FETCH.
  - MEM_WR: req=1, we=1, addr=IR.addr, wdata=ACC. On ack → FETCH.
  - HALT: halted_o=1, no req. start_i → FETCH with PC=0; ACC and flags are retained.
- Handshake:
  - req, we, addr and wdata are held stable until ack is sampled.
  - Ack in the same cycle req first rises completes that cycle (zero-wait).
  - Ack while req=0 is ignored.
  - req drops in the cycle after ack unless the next state issues a new request.
- Arithmetic (modulo 2^DATA_WIDTH):
  - ADD: C=carry-out.
  - SUB: ACC−op, C=1 iff ACC<op (borrow).
  - AND/OR: bitwise.
  - Z=(result==0) on LDA/ADD/SUB/AND/OR.
  - C updates only on ADD/SUB.
- Zero-wait cycle counts: NOP/JMP/JZ/HLT 2, STA 3, LDA/ALU ops 4.
- start_i outside IDLE/HALT is ignored.

Decomposition:
- Package acc_core_pkg holds:
  - opcode_e enum (4-bit)
  - state_e enum (IDLE, FETCH, DECODE, MEM_RD, EXEC, MEM_WR, HALT)
  - OPC_MSB/OPC_LSB constants
- Sub-module acc_core_alu (combinational): op, a, b → result, carry. Its AND path is a generate loop of and_gate per bit.
- The FSM, PC, IR, ACC and flags live in acc_core_ctrl.

Test Plan:
- Reset with mem_ack_i=1 and start_i=0 → pc_o=0, acc_o=0, mem_req_o=0, halted_o=0, and no request for 10 cycles.
- Zero-wait program mem[0]=0x1A, [1]=0x3B, [2]=0x2C, [3]=0xF0, [10]=0xF0, [11]=0x20; start → mem[12]=0x10, c_o=1, z_o=0, halted_o=1 at cycle 13 after start.
- Same program with ack delayed 3 cycles per request → addr/we/wdata stable while req=1; identical final state; halted 21 cycles later than the zero-wait run.
- JZ: mem[10]=0x00 with LDA 10; JZ 5 → pc_o=5. With mem[10]=0x01 → pc_o=2 (fall-through).
- ALU: ACC=0x05 SUB 0x07 → acc_o=0xFE, c_o=1, z_o=0. ACC=0xF0 AND 0x0F → acc_o=0x00, z_o=1, c_o unchanged.
- Boundaries:
  - JMP 15 with mem[15]=0x00 → pc_o wraps to 0 after the fetch.
  - rst_i asserted during MEM_WR before ack → mem_req_o=0 next cycle; memory unchanged.

Source files
------------

// File: rtl/acc_core_pkg.sv
// Shared types for the accumulator core: opcodes, FSM states and
// instruction field positions.
package acc_core_pkg;

  localparam int OPC_MSB = 7;
  localparam int OPC_LSB = 4;
  localparam int OPC_W   = OPC_MSB - OPC_LSB + 1;

  typedef enum logic [3:0] {
    OP_NOP = 4'h0,
    OP_LDA = 4'h1,
    OP_STA = 4'h2,
    OP_ADD = 4'h3,
    OP_SUB = 4'h4,
    OP_AND = 4'h5,
    OP_OR  = 4'h6,
    OP_JMP = 4'h7,
    OP_JZ  = 4'h8,
    OP_HLT = 4'hF
  } opcode_e;

  typedef enum logic [2:0] {
    S_IDLE,
    S_FETCH,
    S_DECODE,
    S_MEM_RD,
    S_EXEC,
    S_MEM_WR,
    S_HALT
  } state_e;

endpackage

// File: rtl/acc_core_alu.sv
// Combinational ALU: accumulator (a) against memory operand (b).
// LDA passes b through so the Z flag can be taken from one place.
module acc_core_alu
  import acc_core_pkg::*;
#(
  parameter int W = 8
) (
  input  opcode_e      op_i,
  input  logic [W-1:0] a_i,
  input  logic [W-1:0] b_i,
  output logic [W-1:0] result_o,
  output logic         carry_o
);

  logic [W-1:0] and_w;
  logic [W:0]   sum_w;
  logic [W:0]   diff_w;

  for (genvar i = 0; i < W; i++) begin : g_and
    and_gate u_and (
      .a_i (a_i[i]),
      .b_i (b_i[i]),
      .y_o (and_w[i])
    );
  end

  assign sum_w  = {1'b0, a_i} + {1'b0, b_i};
  // The extra MSB of the difference is the borrow (a < b).
  assign diff_w = {1'b0, a_i} - {1'b0, b_i};

  always_comb begin
    result_o = a_i;
    carry_o  = 1'b0;
    case (op_i)
      OP_LDA: result_o = b_i;
      OP_ADD: {carry_o, result_o} = sum_w;
      OP_SUB: {carry_o, result_o} = diff_w;
      OP_AND: result_o = and_w;
      OP_OR:  result_o = a_i | b_i;
      default: ;
    endcase
  end

endmodule

// File: rtl/and_gate.sv
// Single-bit AND leaf cell used by the ALU.
module and_gate (
  input  logic a_i,
  input  logic b_i,
  output logic y_o
);
  assign y_o = a_i & b_i;
endmodule

// File: rtl/acc_core_ctrl.sv
// Multi-cycle accumulator processor: fetch/decode/execute FSM over a
// single req/ack memory port, owning PC, IR, ACC and the Z/C flags.
module acc_core_ctrl
  import acc_core_pkg::*;
#(
  parameter int DATA_WIDTH = 8,
  parameter int ADDR_WIDTH = 4
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic                  start_i,
  output logic                  mem_req_o,
  output logic                  mem_we_o,
  output logic [ADDR_WIDTH-1:0] mem_addr_o,
  output logic [DATA_WIDTH-1:0] mem_wdata_o,
  input  logic [DATA_WIDTH-1:0] mem_rdata_i,
  input  logic                  mem_ack_i,
  output logic [DATA_WIDTH-1:0] acc_o,
  output logic [ADDR_WIDTH-1:0] pc_o,
  output logic                  z_o,
  output logic                  c_o,
  output logic                  halted_o
);

  if (DATA_WIDTH != OPC_W + ADDR_WIDTH) begin : g_width_chk
    $error("acc_core_ctrl: DATA_WIDTH must equal 4 + ADDR_WIDTH");
  end

  state_e                state_q, state_d;
  logic [ADDR_WIDTH-1:0] pc_q, pc_d;
  logic [DATA_WIDTH-1:0] ir_q, ir_d;
  logic [DATA_WIDTH-1:0] acc_q, acc_d;
  logic [DATA_WIDTH-1:0] opnd_q, opnd_d;
  logic                  z_q, z_d;
  logic                  c_q, c_d;

  opcode_e               opcode;
  logic [ADDR_WIDTH-1:0] ir_addr;
  logic [DATA_WIDTH-1:0] alu_res;
  logic                  alu_c;

  assign opcode  = opcode_e'(ir_q[DATA_WIDTH-1 -: OPC_W]);
  assign ir_addr = ir_q[ADDR_WIDTH-1:0];

  acc_core_alu #(.W(DATA_WIDTH)) u_alu (
    .op_i     (opcode),
    .a_i      (acc_q),
    .b_i      (opnd_q),
    .result_o (alu_res),
    .carry_o  (alu_c)
  );

  always_comb begin
    state_d     = state_q;
    pc_d        = pc_q;
    ir_d        = ir_q;
    acc_d       = acc_q;
    opnd_d      = opnd_q;
    z_d         = z_q;
    c_d         = c_q;
    mem_req_o   = 1'b0;
    mem_we_o    = 1'b0;
    mem_addr_o  = pc_q;
    mem_wdata_o = acc_q;
    halted_o    = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (start_i) begin
          state_d = S_FETCH;
          pc_d    = '0;
        end
      end
      S_FETCH: begin
        mem_req_o = 1'b1;
        if (mem_ack_i) begin
          ir_d    = mem_rdata_i;
          pc_d    = pc_q + 1'b1;
          state_d = S_DECODE;
        end
      end
      S_DECODE: begin
        case (opcode)
          OP_LDA, OP_ADD, OP_SUB, OP_AND, OP_OR: state_d = S_MEM_RD;
          OP_STA: state_d = S_MEM_WR;
          OP_JMP: begin
            pc_d    = ir_addr;
            state_d = S_FETCH;
          end
          OP_JZ: begin
            if (z_q) pc_d = ir_addr;
            state_d = S_FETCH;
          end
          OP_HLT:  state_d = S_HALT;
          default: state_d = S_FETCH;
        endcase
      end
      S_MEM_RD: begin
        mem_req_o  = 1'b1;
        mem_addr_o = ir_addr;
        if (mem_ack_i) begin
          opnd_d  = mem_rdata_i;
          state_d = S_EXEC;
        end
      end
      S_EXEC: begin
        acc_d = alu_res;
        z_d   = (alu_res == '0);
        // Only arithmetic touches carry; logic ops and loads leave it.
        if (opcode == OP_ADD || opcode == OP_SUB) c_d = alu_c;
        state_d = S_FETCH;
      end
      S_MEM_WR: begin
        mem_req_o  = 1'b1;
        mem_we_o   = 1'b1;
        mem_addr_o = ir_addr;
        if (mem_ack_i) state_d = S_FETCH;
      end
      S_HALT: begin
        halted_o = 1'b1;
        if (start_i) begin
          state_d = S_FETCH;
          pc_d    = '0;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= S_IDLE;
      pc_q    <= '0;
      ir_q    <= '0;
      acc_q   <= '0;
      opnd_q  <= '0;
      z_q     <= 1'b0;
      c_q     <= 1'b0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      ir_q    <= ir_d;
      acc_q   <= acc_d;
      opnd_q  <= opnd_d;
      z_q     <= z_d;
      c_q     <= c_d;
    end
  end

  assign acc_o = acc_q;
  assign pc_o  = pc_q;
  assign z_o   = z_q;
  assign c_o   = c_q;

endmodule

// File: tb/tb_acc_core_ctrl.sv
// Bench for acc_core_ctrl: directed programs plus random programs, all
// checked against an instruction-level reference model.
module tb_acc_core_ctrl;

  logic       clk_i = 1'b0;
  logic       rst_i = 1'b1;
  logic       start_i = 1'b0;
  logic       mem_req_o, mem_we_o, mem_ack_i;
  logic [3:0] mem_addr_o, pc_o;
  logic [7:0] mem_wdata_o, mem_rdata_i, acc_o;
  logic       z_o, c_o, halted_o;

  always #5 clk_i = ~clk_i;

  acc_core_ctrl #(.DATA_WIDTH(8), .ADDR_WIDTH(4)) dut (
    .clk_i       (clk_i),
    .rst_i       (rst_i),
    .start_i     (start_i),
    .mem_req_o   (mem_req_o),
    .mem_we_o    (mem_we_o),
    .mem_addr_o  (mem_addr_o),
    .mem_wdata_o (mem_wdata_o),
    .mem_rdata_i (mem_rdata_i),
    .mem_ack_i   (mem_ack_i),
    .acc_o       (acc_o),
    .pc_o        (pc_o),
    .z_o         (z_o),
    .c_o         (c_o),
    .halted_o    (halted_o)
  );

  int n_cmp = 0;
  int n_err = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Memory with a fixed per-request wait of dly cycles
  logic [7:0] mem [16];
  logic [7:0] img [16];
  logic       load_req  = 1'b0;
  logic       ack_force = 1'b0;
  int         wcnt = 0;
  int         dly  = 0;

  assign mem_ack_i   = ack_force | (mem_req_o && (wcnt >= dly));
  assign mem_rdata_i = mem[mem_addr_o];

  always @(posedge clk_i) begin
    if (load_req) begin
      for (int i = 0; i < 16; i++) mem[i] <= img[i];
      wcnt <= 0;
    end else if (mem_req_o && mem_ack_i) begin
      if (mem_we_o) mem[mem_addr_o] <= mem_wdata_o;
      wcnt <= 0;
    end else if (mem_req_o) begin
      wcnt <= wcnt + 1;
    end else begin
      wcnt <= 0;
    end
  end

  // Request signals must hold while a request is outstanding
  logic        pend = 1'b0;
  logic [13:0] p_vec = '0;
  always @(negedge clk_i) begin
    if (pend)
      chk("hs_stable", 32'({mem_req_o, mem_we_o, mem_addr_o, mem_wdata_o}), 32'(p_vec));
    pend  <= mem_req_o && !mem_ack_i && !rst_i;
    p_vec <= {mem_req_o, mem_we_o, mem_addr_o, mem_wdata_o};
  end

  // Instruction-level reference model
  logic [7:0] m_mem [16];
  logic [7:0] m_acc;
  logic [3:0] m_pc;
  logic       m_z, m_c, m_halt;
  int         m_cyc, m_nreq;

  task automatic model_run();
    logic [7:0] ir, v;
    logic [3:0] a;
    int op, s;
    m_acc = 0; m_z = 0; m_c = 0; m_pc = 0; m_halt = 0; m_cyc = 0; m_nreq = 0;
    for (int n = 0; n < 60 && !m_halt; n++) begin
      ir = m_mem[m_pc];
      m_pc = m_pc + 4'd1;
      m_cyc += 2; m_nreq += 1;
      op = int'(ir[7:4]); a = ir[3:0]; v = m_mem[a];
      case (op)
        1, 3, 4, 5, 6: begin
          m_cyc += 2; m_nreq += 1;
          s = 0;
          case (op)
            1: s = int'(v);
            3: begin s = int'(m_acc) + int'(v); m_c = (s > 255); end
            4: begin s = int'(m_acc) - int'(v); m_c = (s < 0); end
            5: s = int'(m_acc & v);
            default: s = int'(m_acc | v);
          endcase
          m_acc = 8'(s);
          m_z = (m_acc == 0);
        end
        2:  begin m_mem[a] = m_acc; m_cyc += 1; m_nreq += 1; end
        7:  m_pc = a;
        8:  if (m_z) m_pc = a;
        15: m_halt = 1;
        default: ;
      endcase
    end
  endtask

  logic [3:0] pcq [$];
  int         last_cyc;

  task automatic do_reset();
    @(negedge clk_i);
    rst_i = 1'b1; load_req = 1'b1; start_i = 1'b0;
    @(posedge clk_i); #1;
    load_req = 1'b0;
    @(posedge clk_i); #1;
    rst_i = 1'b0;
  endtask

  task automatic clear_img();
    for (int i = 0; i < 16; i++) img[i] = 8'h00;
  endtask

  task automatic run_prog(input string name, input int d, input bit inj);
    int limit;
    for (int i = 0; i < 16; i++) m_mem[i] = img[i];
    model_run();
    do_reset();
    dly = d;
    limit = m_cyc + d * m_nreq + 40;
    @(negedge clk_i); start_i = 1'b1;
    @(posedge clk_i); #1; start_i = 1'b0;
    last_cyc = 0;
    pcq.delete(); pcq.push_back(pc_o);
    while (!halted_o && last_cyc < limit) begin
      @(posedge clk_i); #1;
      last_cyc++;
      if (pc_o != pcq[$]) pcq.push_back(pc_o);
      start_i = (inj && !halted_o && $urandom_range(0, 7) == 0);
    end
    start_i = 1'b0;
    chk({name, "_halted"}, 32'(halted_o), 32'(m_halt));
    chk({name, "_cycles"}, last_cyc, m_cyc + d * m_nreq);
    chk({name, "_acc"}, 32'(acc_o), 32'(m_acc));
    chk({name, "_pc"}, 32'(pc_o), 32'(m_pc));
    chk({name, "_z"}, 32'(z_o), 32'(m_z));
    chk({name, "_c"}, 32'(c_o), 32'(m_c));
    for (int i = 0; i < 16; i++)
      chk($sformatf("%s_mem%0d", name, i), 32'(mem[i]), 32'(m_mem[i]));
  endtask

  function automatic logic [31:0] pc_at(input int idx);
    return (pcq.size() > idx) ? 32'(pcq[idx]) : 32'hFFFF;
  endfunction

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int idx;
    bit seen;
    clear_img();

    // Reset with ack held high and no start
    ack_force = 1'b1;
    do_reset();
    chk("rst_pc", 32'(pc_o), 0);
    chk("rst_acc", 32'(acc_o), 0);
    chk("rst_zc", 32'({z_o, c_o}), 0);
    chk("rst_halted", 32'(halted_o), 0);
    for (int i = 0; i < 10; i++) begin
      @(posedge clk_i); #1;
      chk("rst_noreq", 32'(mem_req_o), 0);
    end
    ack_force = 1'b0;

    // Zero-wait and delayed-ack runs of the same program
    clear_img();
    img[0] = 8'h1A; img[1] = 8'h3B; img[2] = 8'h2C; img[3] = 8'hF0;
    img[10] = 8'hF0; img[11] = 8'h20;
    run_prog("zw", 0, 0);
    chk("zw_cyc13", last_cyc, 13);
    chk("zw_mem12", 32'(mem[12]), 32'h10);
    chk("zw_flags", 32'({c_o, z_o, halted_o}), 32'b101);
    run_prog("dly3", 3, 0);
    chk("dly3_cyc34", last_cyc, 34);
    chk("dly3_mem12", 32'(mem[12]), 32'h10);

    // JZ taken and not taken
    clear_img();
    img[0] = 8'h1A; img[1] = 8'h85; img[2] = 8'hF0; img[5] = 8'hF0; img[10] = 8'h00;
    run_prog("jz_t", 0, 0);
    chk("jz_t_target", pc_at(3), 5);
    img[10] = 8'h01;
    run_prog("jz_n", 1, 0);
    chk("jz_n_fall", pc_at(3), 3);

    // ALU corner cases
    clear_img();
    img[0] = 8'h1A; img[1] = 8'h4B; img[2] = 8'hF0; img[10] = 8'h05; img[11] = 8'h07;
    run_prog("sub", 0, 0);
    chk("sub_acc", 32'(acc_o), 32'hFE);
    chk("sub_cz", 32'({c_o, z_o}), 32'b10);
    clear_img();
    img[0] = 8'h1A; img[1] = 8'h3A; img[2] = 8'h1A; img[3] = 8'h5B; img[4] = 8'hF0;
    img[10] = 8'hF0; img[11] = 8'h0F;
    run_prog("and", 2, 0);
    chk("and_acc", 32'(acc_o), 32'h00);
    chk("and_cz", 32'({c_o, z_o}), 32'b11);

    // JMP 15 then PC wraps to 0 after the fetch at 15
    clear_img();
    img[0] = 8'h8E; img[1] = 8'h1D; img[2] = 8'h7F; img[14] = 8'hF0;
    run_prog("wrap", 0, 0);
    idx = -1;
    foreach (pcq[i]) if (idx < 0 && pcq[i] == 4'hF) idx = i;
    chk("wrap_next", (idx >= 0) ? pc_at(idx + 1) : 32'hFFFF, 0);

    // Reset while a write is outstanding
    clear_img();
    img[0] = 8'h2C; img[12] = 8'hAA;
    do_reset();
    dly = 20;
    @(negedge clk_i); start_i = 1'b1;
    @(posedge clk_i); #1; start_i = 1'b0;
    seen = 0;
    for (int i = 0; i < 40 && !seen; i++) begin
      @(posedge clk_i); #1;
      seen = mem_req_o && mem_we_o;
    end
    chk("wr_seen", 32'(seen), 1);
    rst_i = 1'b1;
    @(posedge clk_i); #1;
    chk("wr_rst_noreq", 32'(mem_req_o), 0);
    chk("wr_rst_mem", 32'(mem[12]), 32'hAA);
    rst_i = 1'b0;
    dly = 0;

    // Random programs that halt within the model's bound
    for (int t = 0; t < 25; t++) begin
      for (int tries = 0; tries < 200; tries++) begin
        for (int i = 0; i < 16; i++) begin
          img[i] = 8'($urandom);
          m_mem[i] = img[i];
        end
        model_run();
        if (m_halt) break;
      end
      run_prog($sformatf("rnd%0d", t), $urandom_range(0, 3), 1);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
